// File: rtl/CacheTypes.sv
// Shared types for the cache/memory arbiter: arbiter state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package CacheTypes;

    typedef enum logic [1:0] {
        State_Idle   = 2'd0,
        State_GrantI = 2'd1,
        State_GrantD = 2'd2
    } MemArbState;

    localparam int DEF_LINE_WIDTH     = 128;
    localparam int DEF_MEM_ADDR_WIDTH = 28;

endpackage

// File: rtl/cache_mem_arbiter_pick.sv
// Grant selection between the I-side and D-side replacers (pure combinational).
// Latency: zero cycles; the result is registered by the arbiter state machine.
// Backpressure: none; the losing side simply keeps its request asserted.
// CACHE_MEM_ARBITER_ROUND_ROBIN_EN selects alternation on contention instead of D-over-I priority.
module cache_mem_arbiter_pick (
    output logic grantD,
    input  logic reqI,
    input  logic reqD
`ifdef CACHE_MEM_ARBITER_ROUND_ROBIN_EN
    ,
    input  logic lastGrantD
`endif
);

`ifdef CACHE_MEM_ARBITER_ROUND_ROBIN_EN
    // On contention the side that did not win last time goes first.
    always_comb begin
        grantD = reqD;
        if (reqI && reqD) begin
            grantD = ~lastGrantD;
        end
    end
`else
    // Fixed priority: any D request beats an I request.
    always_comb begin
        grantD = reqD;
    end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between the I-cache (read) and D-cache (read/write-back) replacers.
// Latency: request seen in Idle at cycle N drives the memory strobe at N+1; one Idle cycle between grants.
// Backpressure: the grant is held until the memory done pulse; the other side waits with its request held.
// Optional build macro CACHE_MEM_ARBITER_ROUND_ROBIN_EN switches contention policy to round-robin.
module cache_mem_arbiter
    import CacheTypes::*;
#(
    parameter int LINE_WIDTH     = DEF_LINE_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [MEM_ADDR_WIDTH-1:0] iReqAddr,
    input  logic                      iReadEnable,
    output logic                      iReadDone,
    output logic [LINE_WIDTH-1:0]     iReadValue,
    input  logic [MEM_ADDR_WIDTH-1:0] dReqAddr,
    input  logic                      dReadEnable,
    input  logic                      dWriteEnable,
    input  logic [LINE_WIDTH-1:0]     dWriteValue,
    output logic                      dReadDone,
    output logic                      dWriteDone,
    output logic [LINE_WIDTH-1:0]     dReadValue,
    output logic [MEM_ADDR_WIDTH-1:0] memAddr,
    output logic                      memReadEnable,
    output logic                      memWriteEnable,
    output logic [LINE_WIDTH-1:0]     memWriteValue,
    input  logic                      memReadDone,
    input  logic                      memWriteDone,
    input  logic [LINE_WIDTH-1:0]     memReadValue
);

    MemArbState                state_q;
    MemArbState                state_d;
    logic                      reqI;
    logic                      reqD;
    logic                      grantD;
    logic [MEM_ADDR_WIDTH-1:0] lastAddr;

    assign reqI = iReadEnable;
    assign reqD = dReadEnable | dWriteEnable;

    // Read data is broadcast; only the done strobes are steered to the granted side.
    assign iReadValue = memReadValue;
    assign dReadValue = memReadValue;

`ifdef CACHE_MEM_ARBITER_ROUND_ROBIN_EN
    logic lastGrantD;

    // Remember which side was granted most recently, updated on grant entry.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lastGrantD <= 1'b0;
        end else if (state_q == State_Idle && state_d == State_GrantD) begin
            lastGrantD <= 1'b1;
        end else if (state_q == State_Idle && state_d == State_GrantI) begin
            lastGrantD <= 1'b0;
        end
    end

    cache_mem_arbiter_pick u_pick (
        .grantD     (grantD),
        .reqI       (reqI),
        .reqD       (reqD),
        .lastGrantD (lastGrantD)
    );
`else
    cache_mem_arbiter_pick u_pick (
        .grantD (grantD),
        .reqI   (reqI),
        .reqD   (reqD)
    );
`endif

    // Arbiter state register; reset forces Idle, which drops the memory strobes at once.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= State_Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Track the address driven during a grant so Idle keeps presenting it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lastAddr <= '0;
        end else if (state_q != State_Idle) begin
            lastAddr <= memAddr;
        end
    end

    // Next state, memory-side mux and done steering.
    always_comb begin
        state_d        = state_q;
        memAddr        = lastAddr;
        memReadEnable  = 1'b0;
        memWriteEnable = 1'b0;
        memWriteValue  = '0;
        iReadDone      = 1'b0;
        dReadDone      = 1'b0;
        dWriteDone     = 1'b0;
        case (state_q)
            State_Idle: begin
                if (reqD || reqI) begin
                    state_d = grantD ? State_GrantD : State_GrantI;
                end
            end
            State_GrantI: begin
                memAddr       = iReqAddr;
                memReadEnable = iReadEnable;
                iReadDone     = memReadDone & iReadEnable;
                // A dropped enable is an abort; a done arriving alongside it is discarded.
                if (!iReadEnable || memReadDone) begin
                    state_d = State_Idle;
                end
            end
            State_GrantD: begin
                memAddr        = dReqAddr;
                memReadEnable  = dReadEnable & ~dWriteEnable;
                memWriteEnable = dWriteEnable;
                memWriteValue  = dWriteValue;
                dReadDone      = memReadDone & dReadEnable & ~dWriteEnable;
                dWriteDone     = memWriteDone & dWriteEnable;
                if (!reqD || (memReadDone && dReadEnable && !dWriteEnable) ||
                    (memWriteDone && dWriteEnable)) begin
                    state_d = State_Idle;
                end
            end
            default: begin
                state_d = State_Idle;
            end
        endcase
    end

    // The D replacer must never ask for a read and a write-back together.
    a_no_dual_d_req: assert property (@(posedge clk) disable iff (!rstN)
        !(dReadEnable && dWriteEnable));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a done-pulse scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_cache_mem_arbiter;

    localparam int LW = 128;
    localparam int AW = 28;

    localparam logic [1:0] K_I  = 2'd1;
    localparam logic [1:0] K_DR = 2'd2;
    localparam logic [1:0] K_DW = 2'd3;

    logic          clk = 1'b0;
    logic          rstN;
    logic [AW-1:0] iReqAddr;
    logic          iReadEnable;
    logic          iReadDone;
    logic [LW-1:0] iReadValue;
    logic [AW-1:0] dReqAddr;
    logic          dReadEnable;
    logic          dWriteEnable;
    logic [LW-1:0] dWriteValue;
    logic          dReadDone;
    logic          dWriteDone;
    logic [LW-1:0] dReadValue;
    logic [AW-1:0] memAddr;
    logic          memReadEnable;
    logic          memWriteEnable;
    logic [LW-1:0] memWriteValue;
    logic          memReadDone;
    logic          memWriteDone;
    logic [LW-1:0] memReadValue;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]    kind;
        logic [LW-1:0] val;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk            (clk),
        .rstN           (rstN),
        .iReqAddr       (iReqAddr),
        .iReadEnable    (iReadEnable),
        .iReadDone      (iReadDone),
        .iReadValue     (iReadValue),
        .dReqAddr       (dReqAddr),
        .dReadEnable    (dReadEnable),
        .dWriteEnable   (dWriteEnable),
        .dWriteValue    (dWriteValue),
        .dReadDone      (dReadDone),
        .dWriteDone     (dWriteDone),
        .dReadValue     (dReadValue),
        .memAddr        (memAddr),
        .memReadEnable  (memReadEnable),
        .memWriteEnable (memWriteEnable),
        .memWriteValue  (memWriteValue),
        .memReadDone    (memReadDone),
        .memWriteDone   (memWriteDone),
        .memReadValue   (memReadValue)
    );

    function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // Monitor: every done pulse must match the next queued expectation.
    always @(negedge clk) begin
        logic [1:0] k;
        exp_t       e;
        if (iReadDone || dReadDone || dWriteDone) begin
            chk("done_onehot", LW'($countones({iReadDone, dReadDone, dWriteDone})), LW'(1));
            k = iReadDone ? K_I : (dReadDone ? K_DR : K_DW);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", LW'(k), LW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("done_kind", LW'(k), LW'(e.kind));
                if (k == K_I)  chk("i_read_data", iReadValue, e.val);
                if (k == K_DR) chk("d_read_data", dReadValue, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input bit wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr ? memWriteEnable : memReadEnable) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("strobe_timeout", LW'(0), LW'(1));
    endtask

    // Memory model: after dly cycles pulse the done for one cycle and queue the expected response.
    task automatic mem_done(input bit wr, input logic [LW-1:0] v, input int dly, input logic [1:0] kind);
        for (int i = 0; i < dly; i++) tick();
        if (wr) memWriteDone = 1'b1;
        else begin
            memReadDone  = 1'b1;
            memReadValue = v;
        end
        exp_q.push_back('{kind: kind, val: v});
        tick();
        memReadDone  = 1'b0;
        memWriteDone = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bit            ok;
        logic [1:0]    first_kind;
        logic [1:0]    second_kind;
        logic [AW-1:0] first_addr;
        logic [AW-1:0] second_addr;
        logic [LW-1:0] wval;

        rstN = 1'b0;
        iReqAddr = '0; iReadEnable = 1'b0;
        dReqAddr = '0; dReadEnable = 1'b0; dWriteEnable = 1'b0; dWriteValue = '0;
        memReadDone = 1'b0; memWriteDone = 1'b0; memReadValue = '0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_read_en",  LW'(memReadEnable),  LW'(0));
        chk("rst_mem_write_en", LW'(memWriteEnable), LW'(0));
        chk("rst_mem_addr",     LW'(memAddr),        LW'(0));
        chk("rst_mem_wval",     memWriteValue,       LW'(0));
        chk("rst_dones", LW'({iReadDone, dReadDone, dWriteDone}), LW'(0));
        tick();
        rstN = 1'b1;
        tick();

        // I-only read, done three cycles after the strobe
        iReqAddr = 28'h0000123; iReadEnable = 1'b1;
        @(negedge clk);
        chk("i_strobe_not_yet", LW'(memReadEnable), LW'(0));
        @(negedge clk);
        chk("i_strobe_next_cycle", LW'(memReadEnable), LW'(1));
        chk("i_mem_addr", LW'(memAddr), LW'(28'h0000123));
        chk("i_no_write", LW'(memWriteEnable), LW'(0));
        mem_done(1'b0, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 3, K_I);
        iReadEnable = 1'b0;
        @(negedge clk);
        chk("i_idle_after", LW'(memReadEnable), LW'(0));
        chk("idle_addr_hold", LW'(memAddr), LW'(28'h0000123));

        // D write-back
        tick();
        wval = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
        dReqAddr = 28'h00000AB; dWriteValue = wval; dWriteEnable = 1'b1;
        wait_strobe(1'b1, ok);
        chk("dw_mem_addr", LW'(memAddr), LW'(28'h00000AB));
        chk("dw_mem_wval", memWriteValue, wval);
        chk("dw_no_read", LW'(memReadEnable), LW'(0));
        mem_done(1'b1, '0, 2, K_DW);
        dWriteEnable = 1'b0;
        @(negedge clk);
        chk("dw_idle_after", LW'(memWriteEnable), LW'(0));

        // Simultaneous I and D read requests
        tick();
`ifdef CACHE_MEM_ARBITER_ROUND_ROBIN_EN
        first_kind = K_I;  first_addr = 28'h0000200;
        second_kind = K_DR; second_addr = 28'h0000300;
`else
        first_kind = K_DR; first_addr = 28'h0000300;
        second_kind = K_I;  second_addr = 28'h0000200;
`endif
        iReqAddr = 28'h0000200; dReqAddr = 28'h0000300;
        iReadEnable = 1'b1; dReadEnable = 1'b1;
        wait_strobe(1'b0, ok);
        chk("both_first_addr", LW'(memAddr), LW'(first_addr));
        mem_done(1'b0, 128'h1111_0000_1111_0000_1111_0000_1111_0000, 2, first_kind);
        if (first_kind == K_I) iReadEnable = 1'b0;
        else dReadEnable = 1'b0;
        @(negedge clk);
        chk("both_idle_gap", LW'(memReadEnable), LW'(0));
        @(negedge clk);
        chk("both_second_strobe", LW'(memReadEnable), LW'(1));
        chk("both_second_addr", LW'(memAddr), LW'(second_addr));
        mem_done(1'b0, 128'h2222_3333_2222_3333_2222_3333_2222_3333, 1, second_kind);
        iReadEnable = 1'b0; dReadEnable = 1'b0;

        // Reset pulse in the middle of a D write grant
        tick();
        dReqAddr = 28'h0000055; dWriteValue = 128'h5A5A; dWriteEnable = 1'b1;
        wait_strobe(1'b1, ok);
        tick();
        rstN = 1'b0; memWriteDone = 1'b1;
        #1;
        chk("rst_mid_write_en", LW'(memWriteEnable), LW'(0));
        chk("rst_mid_addr", LW'(memAddr), LW'(0));
        chk("rst_mid_no_done", LW'(dWriteDone), LW'(0));
        tick();
        rstN = 1'b1; memWriteDone = 1'b0;
        @(negedge clk);
        chk("rst_rel_idle", LW'(memWriteEnable), LW'(0));
        @(negedge clk);
        chk("rst_regrant", LW'(memWriteEnable), LW'(1));
        chk("rst_regrant_addr", LW'(memAddr), LW'(28'h0000055));
        mem_done(1'b1, '0, 1, K_DW);
        dWriteEnable = 1'b0;

        // Abort: I drops its enable in the same cycle memory reports done
        tick();
        iReqAddr = 28'h0000077; iReadEnable = 1'b1;
        wait_strobe(1'b0, ok);
        tick();
        iReadEnable = 1'b0; memReadDone = 1'b1; memReadValue = 128'hBAD;
        @(negedge clk);
        chk("abort_no_done", LW'(iReadDone), LW'(0));
        tick();
        memReadDone = 1'b0;
        dReqAddr = 28'h0000088; dReadEnable = 1'b1;
        @(negedge clk);
        chk("abort_idle", LW'(memReadEnable), LW'(0));
        @(negedge clk);
        chk("abort_next_strobe", LW'(memReadEnable), LW'(1));
        chk("abort_next_addr", LW'(memAddr), LW'(28'h0000088));
        mem_done(1'b0, 128'h3333_4444_5555_6666_7777_8888_9999_AAAA, 1, K_DR);
        dReadEnable = 1'b0;

        // Stray memory dones while Idle; read data still broadcast
        tick();
        memReadDone = 1'b1; memWriteDone = 1'b1; memReadValue = 128'hC0FFEE;
        @(negedge clk);
        chk("stray_no_done", LW'({iReadDone, dReadDone, dWriteDone}), LW'(0));
        chk("bcast_i_value", iReadValue, 128'hC0FFEE);
        chk("bcast_d_value", dReadValue, 128'hC0FFEE);
        chk("stray_addr_hold", LW'(memAddr), LW'(28'h0000088));
        tick();
        memReadDone = 1'b0; memWriteDone = 1'b0;

        repeat (3) tick();
        chk("queue_empty", LW'(exp_q.size()), LW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
